// File: rtl/pipe_pkg.sv
// Shared types for the two-entry skid pipeline stage: FSM state encoding and
// the occupancy count type.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid stage: payload, valid and halted bits.
// Clear has priority over load and returns the payload to BUBBLE, so consumers never see stale data.
module pipe_slot #(
    parameter int                 DATA_W = 64,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_halted,
    output logic              q_valid,
    output logic              q_halted,
    output logic [DATA_W-1:0] q_data
);

    // Slot register with synchronous reset, clear-over-load priority.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q_valid  <= 1'b0;
            q_halted <= 1'b0;
            q_data   <= BUBBLE;
        end else if (clear) begin
            q_valid  <= 1'b0;
            q_halted <= 1'b0;
            q_data   <= BUBBLE;
        end else if (load) begin
            q_valid  <= 1'b1;
            q_halted <= d_halted;
            q_data   <= d_data;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer pipeline stage (e.g. IF/ID) with flush and a fully
// registered in_ready so out_ready never reaches in_ready combinationally.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W = 64,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halted,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halted,
    output logic [1:0]        occupancy
);

    state_e            state_r;
    state_e            state_next_s;
    logic              in_ready_r;
    occ_t              occupancy_r;
    logic              in_fire_s;
    logic              out_fire_s;
    logic              main_load_s;
    logic              main_clear_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic [DATA_W-1:0] main_d_data_s;
    logic              main_d_halted_s;
    logic              main_valid_s;
    logic              main_halted_s;
    logic [DATA_W-1:0] main_data_s;
    logic              skid_valid_s;
    logic              skid_halted_s;
    logic [DATA_W-1:0] skid_data_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = main_valid_s & out_ready;

    // Next-state and slot load/clear decode; flush overrides every handshake.
    always_comb begin
        state_next_s = state_r;
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (flush) begin
            state_next_s = ST_EMPTY;
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_next_s = ST_ONE;
                        main_load_s  = 1'b1;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_load_s  = 1'b1;
                    end else if (in_fire_s) begin
                        state_next_s = ST_FULL;
                        skid_load_s  = 1'b1;
                    end else if (out_fire_s) begin
                        state_next_s = ST_EMPTY;
                        main_clear_s = 1'b1;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_next_s = ST_ONE;
                        main_load_s  = 1'b1;
                        skid_clear_s = 1'b1;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end
    end

    // Main slot refills from the skid entry when one is held, otherwise from the input.
    always_comb begin
        if (skid_valid_s) begin
            main_d_data_s   = skid_data_s;
            main_d_halted_s = skid_halted_s;
        end else begin
            main_d_data_s   = in_data;
            main_d_halted_s = in_halted;
        end
    end

    // State, in_ready and occupancy registers, all derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_FULL);
            occupancy_r <= occ_t'(state_next_s);
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (main_load_s),
        .clear    (main_clear_s),
        .d_data   (main_d_data_s),
        .d_halted (main_d_halted_s),
        .q_valid  (main_valid_s),
        .q_halted (main_halted_s),
        .q_data   (main_data_s)
    );

    pipe_slot #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (skid_load_s),
        .clear    (skid_clear_s),
        .d_data   (in_data),
        .d_halted (in_halted),
        .q_valid  (skid_valid_s),
        .q_halted (skid_halted_s),
        .q_data   (skid_data_s)
    );

    assign in_ready   = in_ready_r;
    assign occupancy  = occupancy_r;
    assign out_valid  = main_valid_s;
    assign out_data   = main_data_s;
    assign out_halted = main_halted_s;

endmodule
